// File: rtl/block_code_pkg.sv
// Shared definitions for the block-code maximum-likelihood decoder:
// FSM state type, metric width helper and the fixed candidate codebook.
package block_code_pkg;

  // Codebook dimensions; the decoder's MAX_LEN / NUM_CW must not exceed these
  localparam int CB_MAX_LEN = 20;
  localparam int CB_NUM_CW  = 32;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    SEARCH  = 2'd2,
    OUTPUT  = 2'd3
  } state_t;

  typedef logic [CB_NUM_CW-1:0][CB_MAX_LEN-1:0] codebook_t;

  // Width that holds a full-precision signed correlation of max_len symbols
  function automatic int metric_w(input int data_width, input int max_len);
    return data_width + $clog2(max_len) + 1;
  endfunction

  // Linear (punctured Hadamard) code: bit n of codeword i is the parity of
  // i AND (n+1). Positions 1,2,4,8,16 make every row distinct, row 0 is all-zero.
  function automatic codebook_t build_codebook();
    codebook_t cb;
    logic [7:0] sel;
    cb = '0;
    for (int i = 0; i < CB_NUM_CW; i++) begin
      for (int n = 0; n < CB_MAX_LEN; n++) begin
        sel      = 8'(i) & 8'(n + 1);
        cb[i][n] = ^sel;
      end
    end
    return cb;
  endfunction

  localparam codebook_t CODEBOOK = build_codebook();

endpackage

// File: rtl/block_code_corr.sv
// Combinational masked correlation of the symbol buffer against one codeword.
// A 0 bit adds the soft symbol, a 1 bit subtracts it; positions at or beyond
// len contribute nothing. Full precision, no saturation.
module block_code_corr
  import block_code_pkg::*;
#(
  parameter int DATA_WIDTH = 4,
  parameter int MAX_LEN    = 20
) (
  input  logic [MAX_LEN*DATA_WIDTH-1:0]                 symbols,
  input  logic [MAX_LEN-1:0]                            codeword,
  input  logic [$clog2(MAX_LEN+1)-1:0]                  len,
  output logic signed [metric_w(DATA_WIDTH, MAX_LEN)-1:0] metric
);

  localparam int MW = metric_w(DATA_WIDTH, MAX_LEN);

  // Sign-extend one soft symbol to metric width
  function automatic logic signed [MW-1:0] sext(input logic [DATA_WIDTH-1:0] s);
    return {{(MW-DATA_WIDTH){s[DATA_WIDTH-1]}}, s};
  endfunction

  // Accumulate signed contributions of the active positions
  always_comb begin
    metric = '0;
    for (int n = 0; n < MAX_LEN; n++) begin
      if (n < int'(len)) begin
        if (codeword[n]) begin
          metric = metric - sext(symbols[n*DATA_WIDTH +: DATA_WIDTH]);
        end else begin
          metric = metric + sext(symbols[n*DATA_WIDTH +: DATA_WIDTH]);
        end
      end
    end
  end

endmodule

// File: rtl/block_code_ml_decoder.sv
// Maximum-likelihood block-code decoder. Collects one frame of soft symbols,
// sweeps the codebook one codeword per cycle keeping the best correlation
// (lower index wins ties), then holds the result until downstream takes it.
module block_code_ml_decoder
  import block_code_pkg::*;
#(
  parameter int DATA_WIDTH = 4,
  parameter int MAX_LEN    = 20,
  parameter int NUM_CW     = 32
) (
  input  logic                                          clk,
  input  logic                                          rst,
  input  logic signed [DATA_WIDTH-1:0]                  rx_symbols,
  input  logic                                          rx_symbols_valid,
  output logic                                          rx_symbols_ready,
  input  logic [$clog2(MAX_LEN+1)-1:0]                  code_length,
  output logic [$clog2(NUM_CW)-1:0]                     dec_index,
  output logic signed [metric_w(DATA_WIDTH, MAX_LEN)-1:0] dec_metric,
  output logic                                          dec_valid,
  input  logic                                          dec_ready,
  output logic                                          len_err
);

  localparam int LEN_W = $clog2(MAX_LEN + 1);
  localparam int IDX_W = $clog2(NUM_CW);
  localparam int MW    = metric_w(DATA_WIDTH, MAX_LEN);

  // Control state
  state_t            state;
  logic [LEN_W-1:0]  pos;
  logic [LEN_W-1:0]  len_eff_q;
  logic              len_err_q;
  logic [IDX_W-1:0]  cw_idx;

  // Frame buffer (data only, never reset)
  logic [MAX_LEN*DATA_WIDTH-1:0] sym_buf;

  // Search datapath
  logic [MAX_LEN-1:0]      cw_row;
  logic signed [MW-1:0]    corr_p0;
  logic signed [MW-1:0]    best_metric_p1;
  logic [IDX_W-1:0]        best_index_p1;
  logic                    better;
  logic signed [MW-1:0]    win_metric;
  logic [IDX_W-1:0]        win_index;

  // Handshake and length decode
  logic              take;
  logic              len_in_bad;
  logic [LEN_W-1:0]  len_in_eff;
  logic [LEN_W-1:0]  wr_pos;
  logic              last_cw;

  assign take       = rx_symbols_valid && rx_symbols_ready;
  assign len_in_bad = (code_length == '0) || (code_length > LEN_W'(MAX_LEN));
  assign len_in_eff = len_in_bad ? LEN_W'(MAX_LEN) : code_length;
  assign wr_pos     = (state == IDLE) ? '0 : pos;
  assign last_cw    = (cw_idx == IDX_W'(NUM_CW - 1));

  // ---- stage p0: correlation of the current codeword against the buffer ----
  assign cw_row = CODEBOOK[cw_idx];

  block_code_corr #(
    .DATA_WIDTH(DATA_WIDTH),
    .MAX_LEN   (MAX_LEN)
  ) u_corr (
    .symbols (sym_buf),
    .codeword(cw_row),
    .len     (len_eff_q),
    .metric  (corr_p0)
  );

  // The first codeword always seeds the running best; later ones must beat it strictly
  assign better     = (cw_idx == '0) || (corr_p0 > best_metric_p1);
  assign win_metric = better ? corr_p0 : best_metric_p1;
  assign win_index  = better ? cw_idx  : best_index_p1;

  // Store each accepted symbol at its frame position
  always_ff @(posedge clk) begin
    for (int n = 0; n < MAX_LEN; n++) begin
      if (take && (wr_pos == LEN_W'(n))) begin
        sym_buf[n*DATA_WIDTH +: DATA_WIDTH] <= rx_symbols;
      end
    end
  end

  // ---- stage p1: frame control, running best and registered result ----
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state            <= IDLE;
      pos              <= '0;
      len_eff_q        <= '0;
      len_err_q        <= 1'b0;
      cw_idx           <= '0;
      best_metric_p1   <= '0;
      best_index_p1    <= '0;
      dec_valid        <= 1'b0;
      dec_index        <= '0;
      dec_metric       <= '0;
      len_err          <= 1'b0;
      rx_symbols_ready <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          rx_symbols_ready <= 1'b1;
          if (take) begin
            len_eff_q <= len_in_eff;
            len_err_q <= len_in_bad;
            cw_idx    <= '0;
            pos       <= LEN_W'(1);
            if (len_in_eff == LEN_W'(1)) begin
              state            <= SEARCH;
              rx_symbols_ready <= 1'b0;
            end else begin
              state <= COLLECT;
            end
          end
        end

        COLLECT: begin
          rx_symbols_ready <= 1'b1;
          if (take) begin
            if (pos == len_eff_q - LEN_W'(1)) begin
              state            <= SEARCH;
              rx_symbols_ready <= 1'b0;
            end else begin
              pos <= pos + LEN_W'(1);
            end
          end
        end

        SEARCH: begin
          rx_symbols_ready <= 1'b0;
          best_metric_p1   <= win_metric;
          best_index_p1    <= win_index;
          if (last_cw) begin
            state      <= OUTPUT;
            cw_idx     <= '0;
            dec_valid  <= 1'b1;
            dec_index  <= win_index;
            dec_metric <= win_metric;
            len_err    <= len_err_q;
          end else begin
            cw_idx <= cw_idx + IDX_W'(1);
          end
        end

        OUTPUT: begin
          rx_symbols_ready <= 1'b0;
          if (dec_ready) begin
            state            <= IDLE;
            dec_valid        <= 1'b0;
            pos              <= '0;
            rx_symbols_ready <= 1'b1;
          end
        end

        default: begin
          state            <= IDLE;
          rx_symbols_ready <= 1'b0;
          dec_valid        <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/block_code_ml_decoder.md
BLOCK_CODE_ML_DECODER -- requirements
Module: block_code_ml_decoder

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 4: signed two's-complement soft-symbol width.
REQ-002 SHALL have parameter MAX_LEN, default 20: maximum codeword length in symbols.
REQ-003 SHALL have parameter NUM_CW, default 32: number of candidate codewords in the codebook.
REQ-004 SHALL have port clk, input, 1: single clock; all logic on rising edge.
REQ-005 SHALL have port rst, input, 1: reset, asynchronous, active-low.
REQ-006 SHALL have port rx_symbols, input, DATA_WIDTH: soft symbol; positive means bit 0 is likely.
REQ-007 SHALL have port rx_symbols_valid, input, 1: rx_symbols is valid this cycle.
REQ-008 SHALL have port rx_symbols_ready, output, 1: block accepts a symbol this cycle.
REQ-009 SHALL have port code_length, input, $clog2(MAX_LEN+1): symbols per codeword; sampled on the first accepted symbol of a frame.
REQ-010 SHALL have port dec_index, output, $clog2(NUM_CW): index of the best codeword.
REQ-011 SHALL have port dec_metric, output, DATA_WIDTH+$clog2(MAX_LEN)+1, signed: winning correlation.
REQ-012 SHALL have port dec_valid, output, 1: dec_index, dec_metric and len_err are valid.
REQ-013 SHALL have port dec_ready, input, 1: downstream accepts the result.
REQ-014 SHALL have port len_err, output, 1: sampled code_length was 0 or greater than MAX_LEN.

Function
REQ-015 SHALL use an FSM with states IDLE, COLLECT, SEARCH, OUTPUT.
REQ-016 Handshake: a symbol SHALL transfer only on a cycle where rx_symbols_valid and rx_symbols_ready are both 1; rx_symbols_ready SHALL be 1 only in IDLE and COLLECT.
REQ-017 IDLE to COLLECT on the first transfer; that transfer SHALL latch code_length into len_q and store the symbol at buffer position 0.
REQ-018 Effective length SHALL be len_q; 0 or greater than MAX_LEN SHALL be replaced by MAX_LEN, and len_err SHALL be set for the frame.
REQ-019 COLLECT SHALL store each transfer at the next position; the transfer that fills position len_eff-1 SHALL move the FSM to SEARCH. If len_eff is 1, the IDLE transfer SHALL go directly to SEARCH.
REQ-020 A cycle with rx_symbols_valid low SHALL neither advance the position counter nor change state (gaps allowed).
REQ-021 SEARCH SHALL evaluate one codeword per cycle, index 0 to NUM_CW-1, taking exactly NUM_CW cycles.
REQ-022 Correlation SHALL be the sum over positions n < len_eff of +sym[n] when codebook bit n is 0 and -sym[n] when it is 1; positions n >= len_eff SHALL contribute 0.
REQ-023 Metric arithmetic SHALL be full precision with no saturation, signed, at width DATA_WIDTH+$clog2(MAX_LEN)+1.
REQ-024 The best codeword SHALL be the maximum metric; on a tie the lower index SHALL win (strict greater-than compare).
REQ-025 SEARCH to OUTPUT after the last codeword; dec_valid SHALL rise on the cycle after the final compare.
REQ-026 Latency from the last symbol transfer to dec_valid SHALL be NUM_CW+1 cycles.
REQ-027 In OUTPUT, outputs SHALL be held stable while dec_ready is low; on dec_valid and dec_ready both 1, the FSM SHALL return to IDLE and dec_valid SHALL be 0 on the next cycle.
REQ-028 rx_symbols_ready SHALL be 1 in the cycle after the output handshake; results SHALL never overlap frames.
REQ-029 code_length changes outside the first transfer of a frame SHALL have no effect on the current frame.

Reset
REQ-030 rst low SHALL immediately force state IDLE, counters 0, best metric register 0, dec_valid 0, dec_index 0, dec_metric 0, len_err 0 and rx_symbols_ready 0.
REQ-031 Reset asserted mid-frame or mid-search SHALL discard the frame; no dec_valid SHALL follow for it.
REQ-032 rx_symbols_ready SHALL return to 1 on the first clock edge after rst deasserts.

Structure
REQ-033 Package block_code_pkg SHALL hold the codebook constant (NUM_CW by MAX_LEN bits), the state enum typedef and the metric-width function.
REQ-034 Sub-module block_code_corr SHALL compute the masked correlation of the buffer against one codebook row combinationally; the top level SHALL register the result.

Verification
REQ-035 Codeword 5 sent noiselessly as +/-7, len 20 -> dec_index 5, dec_metric 140, len_err 0.
REQ-036 All-zero symbols -> dec_index 0 (tie rule), dec_metric 0.
REQ-037 code_length 13 with symbols 14..19 absent from the frame -> result uses positions 0..12 only; next frame starts at the 14th transfer.
REQ-038 code_length 0 -> 20 symbols consumed, len_err 1; dec_ready held low 10 cycles -> outputs stable and rx_symbols_ready 0 throughout.
REQ-039 rst pulsed low at symbol 7 and during SEARCH -> no dec_valid; a clean frame afterwards decodes correctly.
REQ-040 Random valid gaps plus noise at SNR -2 dB with reference-model comparison over 1000 frames -> zero index or metric mismatches.
